// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: entry layout, note codes,
// tone divisor table and the sequencer state encoding.
package melody_pkg;

    localparam int NOTE_W  = 4;
    localparam int DUR_W   = 10;
    localparam int ENTRY_W = NOTE_W + DUR_W;
    localparam int DIV_W   = 18;
    localparam int SONG_LEN = 16;

    localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_C4   = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_D4   = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_E4   = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_F4   = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_G4   = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_A4   = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_B4   = 4'd7;

    // Index 0 is the rest slot; codes 8..15 also map to rest.
    localparam logic [7:0][DIV_W-1:0] DIV_TABLE = {
        18'd101239, 18'd113636, 18'd127551, 18'd143172,
        18'd151685, 18'd170265, 18'd191110, 18'd0
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY,
        S_GAP,
        S_ADV,
        S_DONE
    } state_t;

    function automatic logic is_tone(input logic [NOTE_W-1:0] note);
        return (note[3] == 1'b0) && (note[2:0] != 3'd0);
    endfunction

    function automatic logic [DIV_W-1:0] note_divisor(input logic [NOTE_W-1:0] note);
        return is_tone(note) ? DIV_TABLE[note[2:0]] : '0;
    endfunction

endpackage

// File: rtl/tone_divider.sv
// Programmable square-wave generator: counts 0..D-1 while enabled and drives
// the output high for the first D/2 counts. Output is registered.
module tone_divider
    import melody_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_divisor,
    output logic             o_wave
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;
    logic             r_wave;
    logic [DIV_W-1:0] w_half;
    logic             w_last;

    assign w_half = i_divisor >> 1;
    // >= rather than == so a smaller divisor can never strand the counter
    assign w_last = (r_cnt >= (i_divisor - ONE));
    assign o_wave = r_wave;

    // Phase counter and registered wave; output forced low when not enabled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_wave <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_wave <= 1'b0;
        end else if (i_en) begin
            r_wave <= (r_cnt < w_half);
            r_cnt  <= w_last ? '0 : (r_cnt + ONE);
        end else begin
            r_wave <= 1'b0;
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Melody player: 16-entry song memory, 1 ms timebase and sequencing FSM
// driving one shared tone divider.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; song memory writable
// FETCH   | latch entry[note_idx]; end marker -> DONE, else -> PLAY
// PLAY    | tone (or silence for rests) for dur ms
// GAP     | GAP_MS ms of silence after a tone
// ADV     | step note_idx (wraps 15 -> 0)
// DONE    | one-cycle done pulse; loop restarts at entry 0
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int TICK_DIV  = 50000,
    parameter int GAP_MS    = 20,
    parameter int DIV_SHIFT = 0
) (
    input  logic               i_clock_in,
    input  logic               i_reset_n,
    input  logic               i_wr_en,
    input  logic [3:0]         i_wr_addr,
    input  logic [ENTRY_W-1:0] i_wr_data,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_loop,
    output logic               o_clock_out,
    output logic               o_busy,
    output logic               o_done,
    output logic [3:0]         o_note_idx
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [DUR_W-1:0]  GAP_LOAD  = DUR_W'(GAP_MS);
    localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);
    localparam logic              HAS_GAP   = (GAP_MS != 0);

    logic [ENTRY_W-1:0] r_mem [SONG_LEN];

    state_t             r_state;
    logic [3:0]         r_idx;
    logic [NOTE_W-1:0]  r_note;
    logic [DUR_W-1:0]   r_dur_cnt;
    logic [TICK_W-1:0]  r_tick_cnt;
    logic               r_busy;
    logic               r_done;

    logic [ENTRY_W-1:0] w_entry;
    logic               w_tick;
    logic               w_dur_last;
    logic               w_tone;
    logic               w_div_en;
    logic               w_div_clr;
    logic [DIV_W-1:0]   w_divisor;

    assign w_entry    = r_mem[r_idx];
    assign w_tick     = (r_tick_cnt == TICK_LAST);
    assign w_dur_last = (r_dur_cnt == DUR_ONE);
    assign w_tone     = is_tone(r_note);
    assign w_divisor  = note_divisor(r_note) >> DIV_SHIFT;
    assign w_div_clr  = (r_state == S_FETCH);
    // Enable drops on the cycle the note ends or is aborted, so the
    // registered wave is already low in the following GAP/IDLE cycle.
    assign w_div_en   = (r_state == S_PLAY) && w_tone && !i_stop &&
                        !(w_tick && w_dur_last);

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_note_idx = r_idx;

    // Song memory: written only while idle, deliberately not reset
    always_ff @(posedge i_clock_in) begin
        if ((r_state == S_IDLE) && i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Millisecond timebase, restarted at every fetch so durations are exact
    always_ff @(posedge i_clock_in or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tick_cnt <= '0;
        end else if (!r_busy || (r_state == S_FETCH) || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_ONE;
        end
    end

    // Sequencing FSM with registered busy/done
    always_ff @(posedge i_clock_in or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_note    <= '0;
            r_dur_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_stop && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start && !i_stop) begin
                            r_state <= S_FETCH;
                            r_idx   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        r_note    <= w_entry[ENTRY_W-1:DUR_W];
                        r_dur_cnt <= w_entry[DUR_W-1:0];
                        if (w_entry[DUR_W-1:0] == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (w_tick) begin
                            if (w_dur_last) begin
                                if (w_tone && HAS_GAP) begin
                                    r_state   <= S_GAP;
                                    r_dur_cnt <= GAP_LOAD;
                                end else begin
                                    r_state <= S_ADV;
                                end
                            end else begin
                                r_dur_cnt <= r_dur_cnt - DUR_ONE;
                            end
                        end
                    end
                    S_GAP: begin
                        if (w_tick) begin
                            if (w_dur_last) begin
                                r_state <= S_ADV;
                            end else begin
                                r_dur_cnt <= r_dur_cnt - DUR_ONE;
                            end
                        end
                    end
                    S_ADV: begin
                        r_idx   <= r_idx + 4'd1;
                        r_state <= S_FETCH;
                    end
                    S_DONE: begin
                        if (i_loop) begin
                            r_state <= S_FETCH;
                            r_idx   <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    tone_divider u_tone_divider (
        .i_clk     (i_clock_in),
        .i_rst_n   (i_reset_n),
        .i_clr     (w_div_clr),
        .i_en      (w_div_en),
        .i_divisor (w_divisor),
        .o_wave    (o_clock_out)
    );

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: songs are expanded into an expected per-cycle
// trace of {busy, done, note_idx, clock_out} from the note/duration rules,
// then played with random start/wr_en noise and compared every cycle.
module tb_melody_sequencer;

    localparam int TICK_DIV  = 50;
    localparam int GAP_MS    = 20;
    localparam int DIV_SHIFT = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [13:0] wr_data = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_i = 1'b0;
    logic        clock_out;
    logic        busy;
    logic        done;
    logic [3:0]  note_idx;

    int checks = 0;
    int failures = 0;

    int mem_note [16];
    int mem_dur  [16];

    typedef struct {
        bit busy;
        bit done;
        int idx;
        bit clk;
        bit lp;
    } exp_t;

    exp_t q[$];

    melody_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .GAP_MS    (GAP_MS),
        .DIV_SHIFT (DIV_SHIFT)
    ) dut (
        .i_clock_in  (clk),
        .i_reset_n   (rst_n),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_start     (start),
        .i_stop      (stop),
        .i_loop      (loop_i),
        .o_clock_out (clock_out),
        .o_busy      (busy),
        .o_done      (done),
        .o_note_idx  (note_idx)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int tone_period(input int note);
        case (note)
            1: return 191110 >> DIV_SHIFT;
            2: return 170265 >> DIV_SHIFT;
            3: return 151685 >> DIV_SHIFT;
            4: return 143172 >> DIV_SHIFT;
            5: return 127551 >> DIV_SHIFT;
            6: return 113636 >> DIV_SHIFT;
            7: return 101239 >> DIV_SHIFT;
            default: return 0;
        endcase
    endfunction

    task automatic push(input bit b, input bit dn, input int i, input bit c, input bit lp);
        exp_t e;
        e.busy = b;
        e.done = dn;
        e.idx  = i;
        e.clk  = c;
        e.lp   = lp;
        q.push_back(e);
    endtask

    // Expand the song into the expected trace, starting at the fetch cycle
    task automatic gen(input int passes, input int maxlen);
        q.delete();
        for (int p = 1; p <= passes; p++) begin
            int i;
            bit fin;
            i = 0;
            fin = 0;
            while (!fin) begin
                int d;
                if (q.size() >= maxlen) return;
                push(1, 0, i, 0, 1);
                if (mem_dur[i] == 0) begin
                    push(1, 1, i, 0, p < passes);
                    fin = 1;
                end else begin
                    d = tone_period(mem_note[i]);
                    for (int j = 0; j < mem_dur[i] * TICK_DIV; j++)
                        push(1, 0, i, (d > 0 && j >= 1) ? (((j - 1) % d) < (d / 2)) : 1'b0, 1);
                    if (d > 0)
                        for (int j = 0; j < GAP_MS * TICK_DIV; j++) push(1, 0, i, 0, 1);
                    push(1, 0, i, 0, 1);
                    i = (i + 1) % 16;
                end
            end
        end
        push(0, 0, q[q.size() - 1].idx, 0, 0);
    endtask

    task automatic write_entry(input int a, input int n, input int d);
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_data = {4'(n), 10'(d)};
        step();
        wr_en = 1'b0;
        mem_note[a] = n;
        mem_dur[a]  = d;
    endtask

    // stop_at: -1 none, -2 random cycle; rst_at: -1 none, -2 first tone cycle past entry 0
    task automatic run(input string name, input int passes, input int stop_at,
                       input int rst_at, input int maxlen);
        int s_at;
        int r_at;
        gen(passes, maxlen);
        s_at = stop_at;
        r_at = rst_at;
        if (s_at == -2) s_at = $urandom_range(1, q.size() - 3);
        if (s_at >= 0) begin
            while (q.size() > s_at + 1) void'(q.pop_back());
            push(0, 0, q[s_at].idx, 0, 0);
        end
        if (r_at == -2) begin
            r_at = q.size() / 2;
            for (int k = 0; k < q.size(); k++)
                if (q[k].idx > 0 && q[k].clk) begin
                    r_at = k;
                    break;
                end
        end
        loop_i = (passes > 1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < q.size(); k++) begin
            chk_eq($sformatf("%s cyc%0d", name, k), {busy, done, note_idx, clock_out},
                   {q[k].busy, q[k].done, 4'(q[k].idx), q[k].clk});
            if (k == r_at) begin
                start = 1'b0; stop = 1'b0; wr_en = 1'b0; loop_i = 1'b0;
                #2 rst_n = 1'b0;
                #1 chk_eq($sformatf("%s async_reset", name), {busy, done, note_idx, clock_out}, 0);
                step();
                rst_n = 1'b1;
                step();
                chk_eq($sformatf("%s post_reset_idle", name), {busy, done, note_idx, clock_out}, 0);
                return;
            end
            if (k == q.size() - 1) break;
            loop_i  = q[k].lp;
            stop    = (k == s_at);
            start   = ($urandom_range(0, 63) == 0);
            wr_en   = ($urandom_range(0, 31) == 0);
            wr_addr = 4'($urandom);
            wr_data = 14'($urandom);
            step();
        end
        start = 1'b0; stop = 1'b0; wr_en = 1'b0; loop_i = 1'b0;
        step();
    endtask

    task automatic random_song(input int n);
        for (int i = 0; i < n; i++)
            write_entry(i, $urandom_range(0, 15), $urandom_range(1, 12));
        write_entry(n, $urandom_range(0, 15), 0);
    endtask

    initial begin
        step();
        step();
        chk_eq("reset_state", {busy, done, note_idx, clock_out}, 0);
        rst_n = 1'b1;
        step();

        write_entry(0, 6, 3);
        write_entry(1, 0, 0);
        run("a4_single", 1, -1, -1, 1 << 30);

        write_entry(0, 1, 2);
        write_entry(1, 0, 2);
        write_entry(2, 5, 1);
        write_entry(3, 0, 0);
        run("c4_rest_g4", 1, -1, -1, 1 << 30);
        run("c4_rest_g4_again", 1, -1, -1, 1 << 30);

        write_entry(0, 7, 40);
        write_entry(1, 9, 3);
        write_entry(2, 2, 60);
        write_entry(3, 0, 0);
        run("long_periods", 1, -1, -1, 1 << 30);

        write_entry(0, 3, 5);
        write_entry(1, 11, 0);
        run("loop3", 3, -1, -1, 1 << 30);

        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk_eq("start_stop_idle", busy, 0);
        step();
        chk_eq("start_stop_idle2", busy, 0);

        for (int r = 0; r < 3; r++) begin
            random_song($urandom_range(1, 5));
            run($sformatf("rand%0d", r), 1, -1, -1, 1 << 30);
        end

        random_song($urandom_range(2, 5));
        run("stop_mid", 1, -2, -1, 1 << 30);

        write_entry(0, 7, 40);
        write_entry(1, 9, 3);
        write_entry(2, 2, 60);
        write_entry(3, 0, 0);
        run("reset_mid", 1, -1, -2, 1 << 30);
        run("after_reset", 1, 300, -1, 1 << 30);

        for (int i = 0; i < 16; i++)
            write_entry(i, (i == 5) ? 4 : (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(8, 15)), 1);
        run("wrap", 1, 2399, -1, 2400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
